pulse_train_gen: RTL and testbench

- Inverse of the codebase's positive-edge detector: converts single-cycle trigger pulses back into a shaped level waveform.
- Each accepted trigger produces a high pulse of HIGH_CYCLES clocks, followed by a mandatory low gap of GAP_CYCLES clocks.
- Triggers that arrive while a pulse or gap is in progress are queued in a saturating pending counter.
- Used to drive strobes and handshake levels into downstream CNN control blocks from edge-detected events.

---
 rtl/pulse_train_gen.sv | 118 +++++++++++
 tb/tb_pulse_train_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_gen.sv
// Each accepted trigger becomes a HIGH_CYCLES-wide high pulse followed by at least GAP_CYCLES low clocks.
// Triggers arriving while busy are queued (saturating) in pend_cnt. Define PULSE_TRAIN_GEN_EDGE_IN_EN for level trig.
module pulse_train_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MAX_PEND    = 3,
  localparam int PEND_W     = $clog2(MAX_PEND + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              sig,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam int CNT_MAX = ((HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PEND);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              sig_q, busy_q;
  logic              trig_eff, consume;

`ifdef PULSE_TRAIN_GEN_EDGE_IN_EN
  logic trig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= 1'b0;
    else        trig_q <= trig;
  end

  assign trig_eff = trig & ~trig_q;
`else
  assign trig_eff = trig;
`endif

  // A trigger arriving on the cycle the gap ends cancels against the one consumed.
  always_comb begin
    consume = (state_q == GAP) && (cnt_q == '0) && ((pend_q != '0) || trig_eff);
    pend_d  = pend_q;
    ovf_d   = ovf_q & ~clr_ovf;
    if (state_q != IDLE) begin
      if (consume) begin
        if (!trig_eff) pend_d = pend_q - PEND_W'(1);
      end else if (trig_eff) begin
        if (pend_q < PEND_MAX) pend_d = pend_q + PEND_W'(1);
        else                   ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (trig_eff) begin
            state_q <= HIGH;
            cnt_q   <= HIGH_LOAD;
            sig_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= GAP;
            cnt_q   <= GAP_LOAD;
            sig_q   <= 1'b0;
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (consume) begin
            state_q <= HIGH;
            cnt_q   <= HIGH_LOAD;
            sig_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          sig_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sig      = sig_q;
  assign busy     = busy_q;
  assign pend_cnt = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed waveform checks plus random triggers against a position-based reference model.
module tb_pulse_train_gen;

  localparam int H      = 4;
  localparam int G      = 2;
  localparam int MAXP   = 3;
  localparam int PEND_W = $clog2(MAXP + 1);

  logic              clk;
  logic              rst_n;
  logic              trig;
  logic              clr_ovf;
  logic              sig;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;

  int n_chk = 0;
  int n_bad = 0;

  // reference model: one pulse period is H high clocks then G gap clocks, tracked by position
  bit m_act;
  int m_pos;
  int m_pend;
  bit m_ovf;
  bit m_prev;

  logic [63:0] sig_h, busy_h, ovf_h;
  int          pend_h [0:63];

  pulse_train_gen #(.HIGH_CYCLES(H), .GAP_CYCLES(G), .MAX_PEND(MAXP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .clr_ovf  (clr_ovf),
    .sig      (sig),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pos = 0; m_pend = 0; m_ovf = 0; m_prev = 0;
  endtask

  task automatic model_step(input logic t, input logic c);
    bit te, last, cons, novf;
    te = t;
`ifdef PULSE_TRAIN_GEN_EDGE_IN_EN
    te = t && !m_prev;
    m_prev = t;
`endif
    novf = m_ovf && !c;
    if (!m_act) begin
      if (te) begin m_act = 1; m_pos = 0; end
    end else begin
      last = (m_pos == H + G - 1);
      cons = last && (m_pend > 0 || te);
      if (cons) begin
        if (!te) m_pend--;
      end else if (te) begin
        if (m_pend < MAXP) m_pend++;
        else novf = 1;
      end
      if (!last)     m_pos++;
      else if (cons) m_pos = 0;
      else           m_act = 0;
    end
    m_ovf = novf;
  endtask

  task automatic cyc(input logic t, input logic c);
    trig = t; clr_ovf = c;
    @(posedge clk);
    model_step(t, c);
    #1;
    check("sig",  sig,  (m_act && m_pos < H));
    check("busy", busy, m_act);
    check("pend", pend_cnt, m_pend);
    check("ovf",  ovf,  m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trig = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_sig",  sig, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_ovf",  ovf, 0);
    rst_n = 1'b1;
  endtask

  // history index c holds the outputs during cycle c; bit c of tp/cp is the input during cycle c
  task automatic run_seq(input logic [63:0] tp, input logic [63:0] cp, input int n);
    sig_h = '0; busy_h = '0; ovf_h = '0;
    for (int i = 0; i < 64; i++) pend_h[i] = 0;
    sig_h[0] = sig; busy_h[0] = busy; ovf_h[0] = ovf; pend_h[0] = int'(pend_cnt);
    for (int c = 0; c < n; c++) begin
      cyc(tp[c], cp[c]);
      sig_h[c+1] = sig; busy_h[c+1] = busy; ovf_h[c+1] = ovf; pend_h[c+1] = int'(pend_cnt);
    end
  endtask

  function automatic int max_pend(input int n);
    int m = 0;
    for (int i = 0; i <= n; i++) if (pend_h[i] > m) m = pend_h[i];
    return m;
  endfunction

  initial begin
    do_reset();

    // single trigger
    run_seq(64'h1, 64'h0, 12);
    check("s1_sig",  sig_h,  64'h1E);
    check("s1_busy", busy_h, 64'h7E);
    check("s1_ovf",  ovf_h,  64'h0);
    check("s1_pend", max_pend(12), 0);

    // second trigger queued during first pulse
    do_reset();
    run_seq(64'h5, 64'h0, 16);
    check("s2_pend3", pend_h[3], 1);
    check("s2_sig",   sig_h,  64'h79E);
    check("s2_busy",  busy_h, 64'h1FFE);

    // trigger on final gap cycle with nothing queued
    do_reset();
    run_seq(64'h41, 64'h0, 14);
    check("s4_sig",  sig_h, 64'h79E);
    check("s4_pend", max_pend(14), 0);

`ifndef PULSE_TRAIN_GEN_EDGE_IN_EN
    // saturation and overflow, then clear
    do_reset();
    run_seq(64'h1F, 64'h1 << 30, 33);
    check("s3_pend4", pend_h[4], 3);
    check("s3_sig",   sig_h,  64'h79E79E);
    check("s3_busy",  busy_h, 64'h1FFFFFE);
    check("s3_ovf",   ovf_h,  64'h7FFFFFE0);

    // trigger on final gap cycle with two queued
    do_reset();
    run_seq(64'h47, 64'h0, 10);
    check("s4b_pend6", pend_h[6], 2);
    check("s4b_pend7", pend_h[7], 2);
    check("s4b_sig7",  sig_h[7], 1);
    check("s4b_busy",  busy_h[6:5], 2'b11);

    // asynchronous reset mid-HIGH with two queued
    do_reset();
    run_seq(64'h7, 64'h0, 3);
    check("ar_pre_pend", pend_cnt, 2);
    check("ar_pre_sig",  sig, 1);
`else
    // held level counts once; re-arm after a low cycle
    do_reset();
    run_seq(64'hBFF, 64'h0, 20);
    check("e_sig",  sig_h, 64'hF01E);
    check("e_pend", max_pend(20), 0);

    do_reset();
    run_seq(64'h15, 64'h0, 3);
    check("ar_pre_sig", sig, 1);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("ar_sig",  sig, 0);
    check("ar_busy", busy, 0);
    check("ar_pend", pend_cnt, 0);
    check("ar_ovf",  ovf, 0);
    model_reset();
    trig = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_seq(64'h1, 64'h0, 12);
    check("ar_s1_sig",  sig_h,  64'h1E);
    check("ar_s1_busy", busy_h, 64'h7E);

    // random triggers with varying density
    for (int blk = 0; blk < 8; blk++) begin
      int dens = $urandom_range(10, 90);
      for (int c = 0; c < 250; c++)
        cyc(($urandom_range(0, 99) < dens), ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
